// File: rtl/pipeline_pkg.sv
// Shared pipeline types for the EX/MEM and MEM/WB boundaries.
// Also holds the load/store funct3 codes and the memory-stage FSM states.
package pipeline_pkg;

    localparam int DW = 32;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_GNT,
        WAIT_RDATA
    } mem_state_e;

    typedef struct packed {
        logic          valid;
        logic [DW-1:0] ALUResult;
        logic [DW-1:0] WriteData;
        logic [DW-1:0] PCPlus4;
        logic [DW-1:0] ImmExt;
        logic [4:0]    Rd;
        logic          RegWrite;
        logic [1:0]    ResultSrc;
        logic          MemRead;
        logic          MemWrite;
        logic [2:0]    funct3;
    } exmem_t;

    typedef struct packed {
        logic [DW-1:0] ALUResult;
        logic [DW-1:0] load_data;
        logic [DW-1:0] PCPlus4;
        logic [DW-1:0] ImmExt;
        logic [1:0]    ResultSrc;
        logic [4:0]    Rd;
        logic          RegWrite;
    } memwb_t;

    // Halfword needs an even offset, word needs offset zero.
    function automatic logic misaligned(logic [2:0] f3, logic [1:0] off);
        return ((f3[1:0] == 2'b01) && off[0]) ||
               ((f3[1:0] == 2'b10) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory port: req/gnt address phase, rvalid/rdata response phase.
// master = memory stage, slave = data memory.
interface mem_stage_if;
    import pipeline_pkg::*;

    logic          dmem_req;
    logic          dmem_we;
    logic [DW-1:0] dmem_addr;
    logic [3:0]    dmem_be;
    logic [DW-1:0] dmem_wdata;
    logic          dmem_gnt;
    logic          dmem_rvalid;
    logic [DW-1:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_gnt, dmem_rvalid, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_gnt, dmem_rvalid, dmem_rdata
    );

endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering: store enables/replicated data and load extraction.
// Purely combinational; offset bits beyond the access size are ignored.
module lsu_align
    import pipeline_pkg::*;
(
    input  logic [2:0]    funct3_i,
    input  logic [1:0]    off_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [DW-1:0] rdata_i,
    output logic [3:0]    be_o,
    output logic [DW-1:0] wdata_o,
    output logic [DW-1:0] load_data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = rdata_i[{off_i, 3'b000} +: 8];
    assign half_sel = rdata_i[{off_i[1], 4'b0000} +: 16];

    always_comb begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        case (funct3_i[1:0])
            F3_SB[1:0]: begin
                be_o    = 4'b0001 << off_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            F3_SH[1:0]: begin
                be_o    = off_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{wdata_i[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        load_data_o = rdata_i;
        case (funct3_i)
            F3_LB:   load_data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  load_data_o = {24'b0, byte_sel};
            F3_LH:   load_data_o = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  load_data_o = {16'b0, half_sel};
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: drives the data-memory port, stalls upstream, fills MEM/WB.
// Optional DRAGON_MISALIGN_CHECK_EN traps misaligned accesses without a request.
module mem_stage
    import pipeline_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  exmem_t      inputs,
    output memwb_t      outputs,
    output logic        StallM,
    mem_stage_if.master dmem
`ifdef DRAGON_MISALIGN_CHECK_EN
    ,
    output logic            misalign_o,
    output logic [XLEN-1:0] misalign_addr
`endif
);

    if (XLEN != 32) begin : g_xlen_chk
        $error("mem_stage: only XLEN=32 is supported");
    end

    mem_state_e    state_q;
    memwb_t        outputs_q;
    memwb_t        outputs_d;
    logic          memop;
    logic          mis;
    logic          access;
    logic          store;
    logic          done;
    logic [3:0]    be;
    logic [DW-1:0] wdata;
    logic [DW-1:0] load_data;

    lsu_align u_align (
        .funct3_i    (inputs.funct3),
        .off_i       (inputs.ALUResult[1:0]),
        .wdata_i     (inputs.WriteData),
        .rdata_i     (dmem.dmem_rdata),
        .be_o        (be),
        .wdata_o     (wdata),
        .load_data_o (load_data)
    );

    assign memop = inputs.valid & (inputs.MemRead | inputs.MemWrite);
    assign store = inputs.MemWrite;

`ifdef DRAGON_MISALIGN_CHECK_EN
    assign mis = memop & misaligned(inputs.funct3, inputs.ALUResult[1:0]);
`else
    assign mis = 1'b0;
`endif

    assign access = memop & ~mis;

    // Address-phase fields come straight from the held EX/MEM bundle.
    assign dmem.dmem_we    = store;
    assign dmem.dmem_addr  = {inputs.ALUResult[DW-1:2], 2'b00};
    assign dmem.dmem_be    = be;
    assign dmem.dmem_wdata = wdata;

    always_comb begin
        dmem.dmem_req = 1'b0;
        done          = 1'b0;
        case (state_q)
            IDLE: begin
                dmem.dmem_req = access;
                done          = access & store & dmem.dmem_gnt;
            end
            WAIT_GNT: begin
                dmem.dmem_req = 1'b1;
                done          = store & dmem.dmem_gnt;
            end
            WAIT_RDATA: done = dmem.dmem_rvalid;
            default: ;
        endcase
    end

    assign StallM = (access | (state_q != IDLE)) & ~done;

    always_comb begin
        outputs_d = '0;
        if (!StallM) begin
            outputs_d.ALUResult = inputs.ALUResult;
            outputs_d.PCPlus4   = inputs.PCPlus4;
            outputs_d.ImmExt    = inputs.ImmExt;
            outputs_d.ResultSrc = inputs.ResultSrc;
            outputs_d.Rd        = inputs.Rd;
            outputs_d.RegWrite  = inputs.RegWrite & ~mis;
            outputs_d.load_data = (access & ~store) ? load_data : '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            outputs_q <= '0;
        end else begin
            outputs_q <= outputs_d;
            case (state_q)
                IDLE: begin
                    if (access && !(store && dmem.dmem_gnt))
                        state_q <= dmem.dmem_gnt ? WAIT_RDATA : WAIT_GNT;
                end
                WAIT_GNT: begin
                    if (dmem.dmem_gnt)
                        state_q <= store ? IDLE : WAIT_RDATA;
                end
                WAIT_RDATA: begin
                    if (dmem.dmem_rvalid)
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign outputs = outputs_q;

`ifdef DRAGON_MISALIGN_CHECK_EN
    logic            misalign_q;
    logic [XLEN-1:0] misalign_addr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            misalign_q      <= 1'b0;
            misalign_addr_q <= '0;
        end else begin
            misalign_q      <= mis;
            misalign_addr_q <= mis ? inputs.ALUResult : '0;
        end
    end

    assign misalign_o    = misalign_q;
    assign misalign_addr = misalign_addr_q;
`endif

endmodule
